// File: rtl/apb_irq_router_pkg.sv
// Shared types, field constants and PnP ids for the APB interrupt router.
// Word offsets are relative to the 4 KiB bus1 window.
package apb_irq_router_pkg;

  localparam logic [1:0] IRQ_MODE_LEVEL = 2'd0;
  localparam logic [1:0] IRQ_MODE_RISE  = 2'd1;
  localparam logic [1:0] IRQ_MODE_FALL  = 2'd2;
  localparam logic [1:0] IRQ_MODE_BOTH  = 2'd3;

  localparam int TGT_W = 8;

  localparam logic [3:0] WA_PEND_HI = 4'h8;
  localparam logic [3:0] WA_RAW_HI  = 4'h9;
  localparam logic [9:0] WA_INFO    = 10'h280;

  localparam logic [7:0]  VENDOR_ID = 8'h01;
  localparam logic [11:0] DEVICE_ID = 12'h0a5;

  typedef struct packed {
    logic [TGT_W-1:0] target;
    logic             en;
    logic             inv;
    logic [1:0]       mode;
  } irqcfg_type;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } mapinfo_type;

  typedef struct packed {
    logic [7:0]  vendor;
    logic [11:0] device;
    logic [3:0]  version;
  } dev_config_type;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

  function automatic logic [31:0] cfg_word(irqcfg_type c);
    return {16'b0, c.target, 4'b0, c.en, c.inv, c.mode};
  endfunction

endpackage

// File: rtl/apb_irq_router_slice.sv
// One interrupt source: synchronizer, inversion, edge detect,
// pending flag and the active request fed to the router.
import apb_irq_router_pkg::*;

module irq_src_slice #(
  parameter int sync_stages = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq,
  input  irqcfg_type cfg,
  input  logic       clr,
  input  logic       dis,
  output logic       lvl,
  output logic       pend,
  output logic       active
);

  logic raw;
  logic s;
  logic prev;
  logic lvl_q;
  logic rise;
  logic fall;
  logic edge_sel;
  logic hit;

  if (sync_stages == 0) begin : g_nosync
    assign raw = irq;
  end else begin : g_sync
    logic [sync_stages-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
      end else begin
        sr[0] <= irq;
        for (int i = 1; i < sync_stages; i++)
          sr[i] <= sr[i-1];
      end
    end
    assign raw = sr[sync_stages-1];
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_comb begin
    edge_sel = 1'b0;
    unique case (cfg.mode)
      IRQ_MODE_LEVEL: edge_sel = 1'b0;
      IRQ_MODE_RISE:  edge_sel = rise;
      IRQ_MODE_FALL:  edge_sel = fall;
      IRQ_MODE_BOTH:  edge_sel = rise | fall;
      default:        edge_sel = 1'b0;
    endcase
  end

  assign hit = edge_sel & cfg.en;

  // a new edge beats a W1C in the same cycle; disabling beats both
  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= 1'b0;
      prev  <= 1'b0;
      lvl_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      s     <= raw ^ cfg.inv;
      prev  <= s;
      lvl_q <= s & cfg.en;
      if (dis)
        pend <= 1'b0;
      else if (hit)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

  assign lvl    = s;
  assign active = (cfg.mode == IRQ_MODE_LEVEL) ? lvl_q : pend;

endmodule

// File: rtl/apb_irq_router.sv
// APB-programmable router from peripheral IRQ sources to PLIC lines:
// register decode, per-source CFG array and registered output OR.
import apb_irq_router_pkg::*;

module apb_irq_router #(
  parameter int nsrc        = 32,
  parameter int nout        = 72,
  parameter int sync_stages = 2,
  parameter int tgt_bits    = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  mapinfo_type     i_mapinfo,
  output dev_config_type  o_cfg,
  input  apb_in_type      i_apbi,
  output apb_out_type     o_apbo,
  input  logic [nsrc-1:0] i_irq,
  output logic [nout-1:0] o_irq
);

  localparam int NW = (nsrc + 31) / 32;
  localparam logic [TGT_W-1:0] TMASK =
    TGT_W'((1 << tgt_bits) - 1);

  irqcfg_type        cfg_q [nsrc];
  logic [NW*32-1:0]  pend_v;
  logic [NW*32-1:0]  raw_v;
  logic [nsrc-1:0]   act;
  logic [nsrc-1:0]   clr;
  logic [nsrc-1:0]   dis;
  logic [nout-1:0]   route;
  logic [9:0]        widx;
  logic              hit;
  logic              acc;
  logic              wr;
  logic              is_cfg;
  logic              is_pend;
  logic              is_raw;
  logic              is_info;
  logic [31:0]       rdata;
  logic              rerr;
  logic              pready_q;
  logic [31:0]       prdata_q;
  logic              pslverr_q;

  assign widx = i_apbi.paddr[11:2];
  assign hit  = ((i_apbi.paddr ^ i_mapinfo.base)
                & i_mapinfo.mask) == '0;
  // the cycle pready is high must not start a second access
  assign acc  = i_apbi.psel & i_apbi.penable & ~pready_q;
  assign wr   = acc & i_apbi.pwrite;

  assign is_cfg  = hit & (widx < 10'(nsrc));
  assign is_pend = hit & (widx[9:6] == WA_PEND_HI)
                 & (widx[5:0] < 6'(NW));
  assign is_raw  = hit & (widx[9:6] == WA_RAW_HI)
                 & (widx[5:0] < 6'(NW));
  assign is_info = hit & (widx == WA_INFO);

  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    unique case (1'b1)
      is_cfg: begin
        for (int k = 0; k < nsrc; k++)
          if (widx == 10'(k))
            rdata = cfg_word(cfg_q[k]);
      end
      is_pend: begin
        for (int w = 0; w < NW; w++)
          if (widx[5:0] == 6'(w))
            rdata = pend_v[32*w +: 32];
      end
      is_raw: begin
        for (int w = 0; w < NW; w++)
          if (widx[5:0] == 6'(w))
            rdata = raw_v[32*w +: 32];
      end
      is_info: begin
        rdata = {12'b0, 4'(sync_stages),
                 8'(nout), 8'(nsrc)};
      end
      default: rerr = 1'b1;
    endcase
  end

  always_comb begin
    clr = '0;
    dis = '0;
    for (int k = 0; k < nsrc; k++) begin
      if (wr && is_pend && widx[5:0] == 6'(k / 32))
        clr[k] = i_apbi.pwdata[k % 32];
      if (wr && is_cfg && widx == 10'(k))
        dis[k] = ~i_apbi.pwdata[3];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < nsrc; k++)
        cfg_q[k] <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q <= acc;
      if (acc) begin
        prdata_q  <= i_apbi.pwrite ? '0 : rdata;
        pslverr_q <= rerr;
      end
      for (int k = 0; k < nsrc; k++) begin
        if (wr && is_cfg && widx == 10'(k)) begin
          cfg_q[k].mode   <= i_apbi.pwdata[1:0];
          cfg_q[k].inv    <= i_apbi.pwdata[2];
          cfg_q[k].en     <= i_apbi.pwdata[3];
          cfg_q[k].target <= i_apbi.pwdata[15:8] & TMASK;
        end
      end
    end
  end

  for (genvar k = 0; k < nsrc; k++) begin : g_src
    irq_src_slice #(
      .sync_stages(sync_stages)
    ) u_src (
      .clk    (i_clk),
      .rst    (i_rst),
      .irq    (i_irq[k]),
      .cfg    (cfg_q[k]),
      .clr    (clr[k]),
      .dis    (dis[k]),
      .lvl    (raw_v[k]),
      .pend   (pend_v[k]),
      .active (act[k])
    );
  end

  if (NW * 32 > nsrc) begin : g_pad
    assign pend_v[NW*32-1:nsrc] = '0;
    assign raw_v[NW*32-1:nsrc]  = '0;
  end

  // targets at or above nout never match any line
  always_comb begin
    route = '0;
    for (int t = 0; t < nout; t++)
      for (int k = 0; k < nsrc; k++)
        if (act[k] && cfg_q[k].target == TGT_W'(t))
          route[t] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_irq <= '0;
    else
      o_irq <= route;
  end

  assign o_apbo = '{pready:  pready_q,
                    prdata:  prdata_q,
                    pslverr: pslverr_q};

  assign o_cfg = '{vendor:  VENDOR_ID,
                   device:  DEVICE_ID,
                   version: 4'd1};

endmodule

// File: tb/tb_apb_irq_router.sv
// Bench for apb_irq_router: APB responses go through a scoreboard
// queue, routed lines are checked at exact cycle offsets.
module tb_apb_irq_router;
  import apb_irq_router_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  mapinfo_type    mapinfo;
  dev_config_type pnp;
  apb_in_type     apbi;
  apb_out_type    apbo;
  logic [31:0]    irq;
  logic [71:0]    oirq;
  logic [71:0]    oexp;
  int             checks = 0;
  int             errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  apb_irq_router #(
    .nsrc(32), .nout(72), .sync_stages(2), .tgt_bits(8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mapinfo (mapinfo),
    .o_cfg     (pnp),
    .i_apbi    (apbi),
    .o_apbo    (apbo),
    .i_irq     (irq),
    .o_irq     (oirq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called just after a negedge; returns one cycle after pready
  task automatic apb(input string tag, input logic wr,
                     input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rexp, input logic eexp);
    int   n;
    exp_t e;
    n = 0;
    sbq.push_back('{wr: wr, data: rexp, err: eexp});
    apbi.psel    = 1'b1;
    apbi.penable = 1'b0;
    apbi.pwrite  = wr;
    apbi.paddr   = {20'h0, addr};
    apbi.pwdata  = wdata;
    @(negedge clk);
    apbi.penable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!apbo.pready && n < 8);
    apbi.psel    = 1'b0;
    apbi.penable = 1'b0;
    e = sbq.pop_front();
    if (!apbo.pready) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, 32'(n), 32'd1);
      if (!e.wr)
        chk(tag, apbo.prdata, e.data);
      chk({tag, "_err"}, 32'(apbo.pslverr), 32'(e.err));
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(apbo.pready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    apbi    = '0;
    irq     = '0;
    mapinfo = '{base: 32'h0, mask: 32'hffff_f000};
    rst     = 1'b1;
    cyc(3);
    chk("rst_oirq", 32'(|oirq), 32'd0);
    chk("rst_pready", 32'(apbo.pready), 32'd0);
    chk("rst_prdata", apbo.prdata, 32'd0);
    chk("rst_pslverr", 32'(apbo.pslverr), 32'd0);
    rst = 1'b0;
    cyc(1);

    apb("cfg0_rd", 1'b0, 12'h000, 32'h0, 32'h0, 1'b0);
    apb("info_rd", 1'b0, 12'ha00, 32'h0, 32'h0002_4820, 1'b0);

    apb("cfg3_wr", 1'b1, 12'h00c, 32'h508, 32'h0, 1'b0);
    apb("cfg3_rd", 1'b0, 12'h00c, 32'h0, 32'h508, 1'b0);
    irq[3] = 1'b1;
    cyc(4);
    chk("lvl_on_early", 32'(oirq[5]), 32'd0);
    cyc(1);
    chk("lvl_on", 32'(oirq[5]), 32'd1);
    irq[3] = 1'b0;
    cyc(4);
    chk("lvl_off_early", 32'(oirq[5]), 32'd1);
    cyc(1);
    chk("lvl_off", 32'(oirq[5]), 32'd0);

    apb("cfg7_wr", 1'b1, 12'h01c, 32'h2709, 32'h0, 1'b0);
    irq[7] = 1'b1;
    cyc(1);
    irq[7] = 1'b0;
    cyc(3);
    chk("rise_early", 32'(oirq[39]), 32'd0);
    cyc(1);
    chk("rise_on", 32'(oirq[39]), 32'd1);
    cyc(4);
    chk("rise_hold", 32'(oirq[39]), 32'd1);
    apb("pend_rd", 1'b0, 12'h800, 32'h0, 32'h80, 1'b0);
    apb("pend_w1c", 1'b1, 12'h800, 32'h80, 32'h0, 1'b0);
    chk("w1c_off", 32'(oirq[39]), 32'd0);

    // edge lands on the same clock as the W1C access edge
    irq[7] = 1'b1;
    cyc(2);
    apb("w1c_race", 1'b1, 12'h800, 32'h80, 32'h0, 1'b0);
    cyc(2);
    chk("race_keep", 32'(oirq[39]), 32'd1);
    apb("race_pend", 1'b0, 12'h800, 32'h0, 32'h80, 1'b0);
    irq[7] = 1'b0;

    apb("cfg1_wr", 1'b1, 12'h004, 32'h4608, 32'h0, 1'b0);
    apb("cfg2_wr", 1'b1, 12'h008, 32'h460e, 32'h0, 1'b0);
    cyc(6);
    chk("or_idle", 32'(oirq[70]), 32'd0);
    apb("raw_rd", 1'b0, 12'h900, 32'h0, 32'h4, 1'b0);
    irq[1] = 1'b1;
    cyc(6);
    chk("or_src1", 32'(oirq[70]), 32'd1);
    irq[1] = 1'b0;
    cyc(6);
    chk("or_src1_off", 32'(oirq[70]), 32'd0);
    irq[2] = 1'b1;
    cyc(6);
    chk("or_src2", 32'(oirq[70]), 32'd1);
    irq[2] = 1'b0;
    cyc(6);
    chk("or_src2_hold", 32'(oirq[70]), 32'd1);
    apb("pend_rd2", 1'b0, 12'h800, 32'h0, 32'h84, 1'b0);
    apb("pend_clr2", 1'b1, 12'h800, 32'h4, 32'h0, 1'b0);
    chk("or_clr", 32'(oirq[70]), 32'd0);
    chk("or_keep39", 32'(oirq[39]), 32'd1);

    apb("cfg9_wr", 1'b1, 12'h024, 32'h5009, 32'h0, 1'b0);
    irq[9] = 1'b1;
    cyc(1);
    irq[9] = 1'b0;
    cyc(6);
    oexp     = '0;
    oexp[39] = 1'b1;
    chk("oor_route", 32'(oirq == oexp), 32'd1);
    apb("oor_pend", 1'b0, 12'h800, 32'h0, 32'h280, 1'b0);

    apb("cfg7_dis", 1'b1, 12'h01c, 32'h2700, 32'h0, 1'b0);
    apb("dis_pend", 1'b0, 12'h800, 32'h0, 32'h200, 1'b0);
    chk("dis_off", 32'(oirq[39]), 32'd0);

    apb("bad_rd", 1'b0, 12'hc00, 32'h0, 32'h0, 1'b1);

    irq[1] = 1'b1;
    cyc(6);
    chk("pre_rst_on", 32'(oirq[70]), 32'd1);
    apbi.psel    = 1'b1;
    apbi.penable = 1'b0;
    apbi.pwrite  = 1'b1;
    apbi.paddr   = 32'h0000_000c;
    apbi.pwdata  = 32'h0000_0508;
    cyc(1);
    apbi.penable = 1'b1;
    rst          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_acc_pready", 32'(apbo.pready), 32'd0);
    end
    apbi = '0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rst2_oirq", 32'(|oirq), 32'd0);
    chk("rst2_pready", 32'(apbo.pready), 32'd0);
    chk("rst2_prdata", apbo.prdata, 32'd0);
    chk("rst2_pslverr", 32'(apbo.pslverr), 32'd0);
    apb("rst2_cfg3", 1'b0, 12'h00c, 32'h0, 32'h0, 1'b0);
    apb("rst2_pend", 1'b0, 12'h800, 32'h0, 32'h0, 1'b0);
    cyc(6);
    chk("rst2_oirq_late", 32'(|oirq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
